capture_sequencer: RTL and testbench

Capture control state machine in the `adc_sampleclk` domain that consumes the capture settings produced by the USB-side register file: arm, trigger settings, offset, presamples, maxsamples, downsample and segmenting. It qualifies the trigger, counts pre- and post-trigger samples, and drives the sample FIFO write strobe. It also reports capture state, segment progress and measured trigger duration back to the register file.

---
 rtl/capture_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture control FSM in the adc_sampleclk domain: trigger qualification, pre/post sample
// counting, segmenting and FIFO write strobe. Define CAPTURE_TRIGLEN_EN to build the trigger_length counter.
module capture_sequencer #(
  parameter int pSEG_W = 16
) (
  input  logic              adc_sampleclk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trigger_in,
  input  logic              trigger_mode,
  input  logic              trigger_wait,
  input  logic              trigger_now,
  input  logic [31:0]       trigger_offset,
  input  logic [14:0]       presamples,
  input  logic [31:0]       maxsamples,
  input  logic [12:0]       downsample,
  input  logic [pSEG_W-1:0] num_segments,
  input  logic [19:0]       segment_cycles,
  input  logic              segment_cycle_counter_en,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic              fifo_pre,
  output logic              capture_active,
  output logic              capture_done,
  output logic              triggered,
  output logic              overflow,
  output logic [pSEG_W-1:0] seg_count,
  output logic [31:0]       trigger_length,
  output logic [2:0]        capture_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITLOW = 3'd1,
    S_ARMED   = 3'd2,
    S_OFFSET  = 3'd3,
    S_CAPTURE = 3'd4,
    S_SEGWAIT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state;
  logic        arm_q;
  logic        trig_q;
  logic [14:0] pre_cnt;
  logic [31:0] post_cnt;
  logic [31:0] off_cnt;
  logic [12:0] dec_cnt;
  logic [19:0] seg_cyc;

  logic [31:0]     pre_ext;
  logic [31:0]     pre_eff;
  logic [31:0]     post_total;
  logic            dec_zero;
  logic [12:0]     dec_next;
  logic            pre_done;
  logic            post_left;
  logic            arm_rise;
  logic            trig_accept;
  logic            seg_last;
  logic [pSEG_W:0] seg_inc;
  logic [pSEG_W:0] seg_target;

  // Handshake: fifo_wr is a one-cycle strobe with no back-pressure; fifo_full sampled in the
  // same cycle as a pending write suppresses it and ends the capture with overflow set.
  assign pre_ext     = {17'd0, presamples};
  assign pre_eff     = (pre_ext < maxsamples) ? pre_ext : maxsamples;
  assign post_total  = maxsamples - pre_eff;
  assign dec_zero    = (dec_cnt == 13'd0);
  assign dec_next    = (dec_cnt >= downsample) ? 13'd0 : dec_cnt + 13'd1;
  assign pre_done    = ({17'd0, pre_cnt} >= pre_eff);
  assign post_left   = (post_cnt < post_total);
  assign arm_rise    = arm & ~arm_q;
  assign trig_accept = (state == S_ARMED) && arm && pre_done && trig_q;
  assign seg_inc     = {1'b0, seg_count} + (pSEG_W+1)'(1);
  assign seg_target  = (num_segments == '0) ? (pSEG_W+1)'(1) : {1'b0, num_segments};
  assign seg_last    = (seg_inc >= seg_target);
  assign capture_state = state;

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      state          <= S_IDLE;
      arm_q          <= 1'b0;
      trig_q         <= 1'b0;
      fifo_wr        <= 1'b0;
      fifo_pre       <= 1'b0;
      capture_active <= 1'b0;
      capture_done   <= 1'b0;
      triggered      <= 1'b0;
      overflow       <= 1'b0;
      seg_count      <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      off_cnt        <= '0;
      dec_cnt        <= '0;
      seg_cyc        <= '0;
    end else begin
      arm_q    <= arm;
      trig_q   <= (trigger_in ^ ~trigger_mode) | trigger_now;
      fifo_wr  <= 1'b0;
      fifo_pre <= 1'b0;
      if (seg_cyc != '1) seg_cyc <= seg_cyc + 20'd1;

      // Disarm has priority over every state transition, including a same-cycle trigger.
      if (!arm) begin
        state          <= S_IDLE;
        capture_active <= 1'b0;
        capture_done   <= 1'b0;
        triggered      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_rise) begin
              seg_count      <= '0;
              triggered      <= 1'b0;
              overflow       <= 1'b0;
              capture_active <= 1'b1;
              pre_cnt        <= '0;
              dec_cnt        <= '0;
              state          <= trigger_wait ? S_WAITLOW : S_ARMED;
            end
          end
          S_WAITLOW: begin
            if (!trig_q) begin
              state   <= S_ARMED;
              pre_cnt <= '0;
              dec_cnt <= '0;
            end
          end
          S_ARMED: begin
            if (trig_accept) begin
              state     <= S_OFFSET;
              off_cnt   <= trigger_offset;
              triggered <= 1'b1;
              seg_cyc   <= 20'd1;
              post_cnt  <= '0;
            end else begin
              dec_cnt <= dec_next;
              if (dec_zero && !pre_done) begin
                if (fifo_full) begin
                  overflow       <= 1'b1;
                  capture_active <= 1'b0;
                  capture_done   <= 1'b1;
                  state          <= S_DONE;
                end else begin
                  fifo_wr  <= 1'b1;
                  fifo_pre <= 1'b1;
                  pre_cnt  <= pre_cnt + 15'd1;
                end
              end
            end
          end
          S_OFFSET: begin
            if (off_cnt == 32'd0) begin
              state   <= S_CAPTURE;
              dec_cnt <= '0;
            end else begin
              off_cnt <= off_cnt - 32'd1;
            end
          end
          S_CAPTURE: begin
            if (!post_left) begin
              seg_count <= seg_inc[pSEG_W-1:0];
              if (seg_last) begin
                capture_active <= 1'b0;
                capture_done   <= 1'b1;
                state          <= S_DONE;
              end else if (segment_cycle_counter_en) begin
                state <= S_SEGWAIT;
              end else begin
                state   <= trigger_wait ? S_WAITLOW : S_ARMED;
                pre_cnt <= '0;
                dec_cnt <= '0;
              end
            end else begin
              dec_cnt <= dec_next;
              if (dec_zero) begin
                if (fifo_full) begin
                  overflow       <= 1'b1;
                  capture_active <= 1'b0;
                  capture_done   <= 1'b1;
                  state          <= S_DONE;
                end else begin
                  fifo_wr  <= 1'b1;
                  post_cnt <= post_cnt + 32'd1;
                end
              end
            end
          end
          S_SEGWAIT: begin
            // Counter runs from the previous trigger; reaching or passing the period acts as a trigger.
            if (seg_cyc >= segment_cycles) begin
              state    <= S_OFFSET;
              off_cnt  <= trigger_offset;
              seg_cyc  <= 20'd1;
              post_cnt <= '0;
            end
          end
          S_DONE: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CAPTURE_TRIGLEN_EN
  logic tl_run;
  logic tl_seen;

  // Measures only the first accepted trigger after arming; the accepting cycle counts as one.
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      trigger_length <= '0;
      tl_run         <= 1'b0;
      tl_seen        <= 1'b0;
    end else if (state == S_IDLE && arm && arm_rise) begin
      trigger_length <= '0;
      tl_run         <= 1'b0;
      tl_seen        <= 1'b0;
    end else if (trig_accept && !tl_seen) begin
      trigger_length <= 32'd1;
      tl_run         <= 1'b1;
      tl_seen        <= 1'b1;
    end else if (tl_run) begin
      if (!trig_q) tl_run <= 1'b0;
      else if (trigger_length != 32'hFFFF_FFFF) trigger_length <= trigger_length + 32'd1;
    end
  end
`else
  assign trigger_length = 32'd0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: write scoreboard keyed on {fifo_pre, cycle} plus per-scenario status checks.
module tb_capture_sequencer;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        trigger_in;
  logic        trigger_mode;
  logic        trigger_wait;
  logic        trigger_now;
  logic [31:0] trigger_offset;
  logic [14:0] presamples;
  logic [31:0] maxsamples;
  logic [12:0] downsample;
  logic [15:0] num_segments;
  logic [19:0] segment_cycles;
  logic        segment_cycle_counter_en;
  logic        fifo_full;
  logic        fifo_wr;
  logic        fifo_pre;
  logic        capture_active;
  logic        capture_done;
  logic        triggered;
  logic        overflow;
  logic [15:0] seg_count;
  logic [31:0] trigger_length;
  logic [2:0]  capture_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;
  logic [32:0] got_w;

  capture_sequencer #(.pSEG_W(16)) dut (
    .adc_sampleclk            (clk),
    .reset                    (reset),
    .arm                      (arm),
    .trigger_in               (trigger_in),
    .trigger_mode             (trigger_mode),
    .trigger_wait             (trigger_wait),
    .trigger_now              (trigger_now),
    .trigger_offset           (trigger_offset),
    .presamples               (presamples),
    .maxsamples               (maxsamples),
    .downsample               (downsample),
    .num_segments             (num_segments),
    .segment_cycles           (segment_cycles),
    .segment_cycle_counter_en (segment_cycle_counter_en),
    .fifo_full                (fifo_full),
    .fifo_wr                  (fifo_wr),
    .fifo_pre                 (fifo_pre),
    .capture_active           (capture_active),
    .capture_done             (capture_done),
    .triggered                (triggered),
    .overflow                 (overflow),
    .seg_count                (seg_count),
    .trigger_length           (trigger_length),
    .capture_state            (capture_state)
  );

  // Clock and cycle index: cyc equals the number of rising edges seen so far.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && fifo_wr === 1'b1) begin
      total++;
      got_w = {fifo_pre, 32'(cyc)};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got write pre=%0b at cycle %0d, want no write", fifo_pre, cyc);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          bad++;
          $display("FAIL wr_match: got pre=%0b cycle=%0d, want pre=%0b cycle=%0d",
                   got_w[32], got_w[31:0], exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg(input int pre, input int mx, input int off, input int ds,
                     input int nseg, input int scyc, input bit segen, input bit twait);
    presamples               = pre[14:0];
    maxsamples               = mx;
    trigger_offset           = off;
    downsample               = ds[12:0];
    num_segments             = nseg[15:0];
    segment_cycles           = scyc[19:0];
    segment_cycle_counter_en = segen;
    trigger_wait             = twait;
  endtask

  task automatic push_w(input bit pre, input int c);
    exp_q.push_back({pre, 32'(c)});
  endtask

  task automatic disarm_all();
    arm         = 1'b0;
    trigger_in  = 1'b0;
    trigger_now = 1'b0;
    fifo_full   = 1'b0;
    trigger_mode = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arm = 1'b0; trigger_in = 1'b0; trigger_mode = 1'b1; trigger_now = 1'b0; fifo_full = 1'b0;
    cfg(0, 0, 0, 0, 1, 0, 1'b0, 1'b0);
    tick(3);
    total++;
    if ({fifo_wr, fifo_pre, capture_active, capture_done, triggered, overflow} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, want 000000",
               {fifo_wr, fifo_pre, capture_active, capture_done, triggered, overflow});
    end
    total++;
    if (seg_count !== 16'd0 || trigger_length !== 32'd0) begin
      bad++;
      $display("FAIL reset_counts: got seg=%0d tl=%0d, want 0 0", seg_count, trigger_length);
    end
    reset = 1'b0;
    tick(2);
  endtask

  // 4 presamples, 6 post samples, trigger 8 cycles after arming.
  task automatic test_basic();
    int n, t;
    cfg(4, 10, 0, 0, 1, 0, 1'b0, 1'b0);
    n = cyc;
    arm = 1'b1;
    for (int i = 1; i <= 4; i++) push_w(1'b1, n + 1 + i);
    tick(1);
    total++;
    if (capture_active !== 1'b1) begin
      bad++; $display("FAIL basic_active: got %b, want 1", capture_active);
    end
    wait_until(n + 8);
    trigger_in = 1'b1;
    t = n + 9;
    for (int i = 0; i < 6; i++) push_w(1'b0, t + 3 + i);
    wait_until(t + 8);
    total++;
    if (capture_done !== 1'b0) begin
      bad++; $display("FAIL basic_done_early: got %b, want 0", capture_done);
    end
    tick(1);
    total++;
    if ({capture_done, capture_active, triggered} !== 3'b101 || seg_count !== 16'd1) begin
      bad++;
      $display("FAIL basic_done: got done/active/trig=%b seg=%0d, want 101 seg=1",
               {capture_done, capture_active, triggered}, seg_count);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL basic_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    disarm_all();
    total++;
    if ({capture_done, capture_active, triggered} !== 3'b000) begin
      bad++; $display("FAIL basic_disarm: got %b, want 000", {capture_done, capture_active, triggered});
    end
  endtask

  // Active-low trigger arriving before presamples are complete must be ignored.
  task automatic test_early_trigger();
    int n, t;
    cfg(4, 10, 2, 0, 1, 0, 1'b0, 1'b0);
    trigger_mode = 1'b0;
    trigger_in   = 1'b1;
    tick(3);
    n = cyc;
    arm = 1'b1;
    for (int i = 1; i <= 4; i++) push_w(1'b1, n + 1 + i);
    tick(1);
    trigger_in = 1'b0;
    tick(2);
    trigger_in = 1'b1;
    wait_until(n + 11);
    total++;
    if (triggered !== 1'b0) begin
      bad++; $display("FAIL early_ignored: got triggered=%b, want 0", triggered);
    end
    wait_until(n + 12);
    trigger_in = 1'b0;
    t = n + 13;
    for (int i = 0; i < 6; i++) push_w(1'b0, t + 5 + i);
    wait_until(t + 11);
    total++;
    if (capture_done !== 1'b1 || triggered !== 1'b1) begin
      bad++; $display("FAIL early_done: got done=%b trig=%b, want 1 1", capture_done, triggered);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL early_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    disarm_all();
  endtask

  // trigger_wait with trigger already active, then decimated capture every 3rd cycle.
  task automatic test_downsample();
    int n, t;
    cfg(0, 6, 1, 2, 1, 0, 1'b0, 1'b1);
    trigger_in = 1'b1;
    tick(2);
    n = cyc;
    arm = 1'b1;
    wait_until(n + 5);
    trigger_in = 1'b0;
    wait_until(n + 8);
    total++;
    if (triggered !== 1'b0 || capture_active !== 1'b1) begin
      bad++; $display("FAIL ds_waitlow: got trig=%b active=%b, want 0 1", triggered, capture_active);
    end
    wait_until(n + 9);
    trigger_in = 1'b1;
    t = n + 10;
    for (int i = 0; i < 6; i++) push_w(1'b0, t + 4 + 3 * i);
    wait_until(t + 19);
    total++;
    if (capture_done !== 1'b0) begin
      bad++; $display("FAIL ds_done_early: got %b, want 0", capture_done);
    end
    tick(1);
    total++;
    if (capture_done !== 1'b1) begin
      bad++; $display("FAIL ds_done: got %b, want 1", capture_done);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL ds_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    disarm_all();
  endtask

  // Three segments; later ones self-triggered every 100 cycles; first trigger via trigger_now.
  task automatic test_segments();
    int n, t;
    cfg(2, 6, 0, 0, 3, 100, 1'b1, 1'b0);
    n = cyc;
    arm = 1'b1;
    push_w(1'b1, n + 2);
    push_w(1'b1, n + 3);
    wait_until(n + 5);
    trigger_now = 1'b1;
    t = n + 6;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) push_w(1'b0, t + 3 + 100 * k + i);
    tick(1);
    trigger_now = 1'b0;
    wait_until(t + 50);
    total++;
    if (seg_count !== 16'd1 || capture_active !== 1'b1) begin
      bad++; $display("FAIL seg_first: got seg=%0d active=%b, want 1 1", seg_count, capture_active);
    end
    wait_until(t + 150);
    total++;
    if (seg_count !== 16'd2) begin
      bad++; $display("FAIL seg_second: got seg=%0d, want 2", seg_count);
    end
    wait_until(t + 206);
    total++;
    if (capture_done !== 1'b0) begin
      bad++; $display("FAIL seg_done_early: got %b, want 0", capture_done);
    end
    tick(1);
    total++;
    if (capture_done !== 1'b1 || seg_count !== 16'd3) begin
      bad++; $display("FAIL seg_done: got done=%b seg=%0d, want 1 3", capture_done, seg_count);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL seg_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    disarm_all();
  endtask

  // FIFO full mid-capture, disarm during OFFSET, and disarm racing a trigger.
  task automatic test_overflow_disarm();
    int n, t;
    cfg(0, 8, 0, 0, 1, 0, 1'b0, 1'b0);
    n = cyc;
    arm = 1'b1;
    wait_until(n + 2);
    trigger_in = 1'b1;
    t = n + 3;
    push_w(1'b0, t + 3);
    push_w(1'b0, t + 4);
    wait_until(t + 4);
    fifo_full = 1'b1;
    tick(1);
    total++;
    if (overflow !== 1'b1 || capture_done !== 1'b1 || fifo_wr !== 1'b0) begin
      bad++; $display("FAIL ovf_flags: got ovf=%b done=%b wr=%b, want 1 1 0", overflow, capture_done, fifo_wr);
    end
    tick(3);
    disarm_all();
    total++;
    if (overflow !== 1'b1 || capture_done !== 1'b0) begin
      bad++; $display("FAIL ovf_hold: got ovf=%b done=%b, want 1 0", overflow, capture_done);
    end

    cfg(0, 4, 20, 0, 1, 0, 1'b0, 1'b0);
    n = cyc;
    arm = 1'b1;
    wait_until(n + 2);
    trigger_in = 1'b1;
    wait_until(n + 6);
    total++;
    if (capture_active !== 1'b1 || triggered !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL offset_run: got active=%b trig=%b ovf=%b, want 1 1 0", capture_active, triggered, overflow);
    end
    arm = 1'b0;
    tick(1);
    total++;
    if (capture_active !== 1'b0 || triggered !== 1'b0) begin
      bad++; $display("FAIL offset_disarm: got active=%b trig=%b, want 0 0", capture_active, triggered);
    end
    tick(30);
    disarm_all();

    cfg(0, 4, 0, 0, 1, 0, 1'b0, 1'b0);
    n = cyc;
    arm = 1'b1;
    wait_until(n + 3);
    trigger_in = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
    total++;
    if (triggered !== 1'b0 || capture_active !== 1'b0 || trigger_length !== 32'd0) begin
      bad++; $display("FAIL race_disarm: got trig=%b active=%b tl=%0d, want 0 0 0", triggered, capture_active, trigger_length);
    end
    tick(10);
    disarm_all();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL ovf_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Trigger held active for 37 cycles.
  task automatic test_trigger_length();
    int n, t;
    logic [31:0] exp_tl;
`ifdef CAPTURE_TRIGLEN_EN
    exp_tl = 32'd37;
`else
    exp_tl = 32'd0;
`endif
    cfg(0, 2, 0, 0, 1, 0, 1'b0, 1'b0);
    n = cyc;
    arm = 1'b1;
    wait_until(n + 3);
    trigger_in = 1'b1;
    t = n + 4;
    push_w(1'b0, t + 3);
    push_w(1'b0, t + 4);
    wait_until(n + 40);
    trigger_in = 1'b0;
    wait_until(n + 45);
    total++;
    if (trigger_length !== exp_tl) begin
      bad++; $display("FAIL trig_len: got %0d, want %0d", trigger_length, exp_tl);
    end
    total++;
    if (capture_done !== 1'b1) begin
      bad++; $display("FAIL trig_len_done: got %b, want 1", capture_done);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL tl_pending: got %0d writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    disarm_all();
    total++;
    if (trigger_length !== exp_tl) begin
      bad++; $display("FAIL trig_len_hold: got %0d, want %0d", trigger_length, exp_tl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_trigger();
    test_downsample();
    test_segments();
    test_overflow_disarm();
    test_trigger_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
